sbox_nibble_sequencer: RTL



---
 rtl/sbox_nibble_sequencer.sv | 70 +++++++
 1 files changed

// File: rtl/sbox_nibble_sequencer.sv
// Nibble-serial S-box driver: takes a full state, walks it through one
// shared 4-bit S-box LSB nibble first, and hands back the substituted state.
module sbox_nibble_sequencer #(
  parameter int NIBBLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_state,
  output logic [3:0]             sbox_in,
  input  logic [3:0]             sbox_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_state,
  output logic                   busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  src;
  logic [W-1:0]  res;
  logic [CW-1:0] cnt;

  logic last;
  assign last = (cnt == CW'(NIBBLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      src   <= '0;
      res   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            src   <= in_state;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // results enter at the top so nibble 0 ends up at the LSB
          res <= {sbox_out, res[W-1:4]};
          src <= src >> 4;
          if (last) state <= DONE;
          else      cnt   <= cnt + 1'b1;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sbox_in   = (state == RUN) ? src[3:0] : 4'h0;
  assign out_state = res;

endmodule
